// File: rtl/sample_out_port.sv
// sample_out_port: memory-mapped sample FIFO drained at a programmable rate
// onto a registered DAC sample bus with a one-cycle strobe.
module sample_out_port #(
    parameter int          DATA_W    = 8,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              sel,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_strobe,
    output logic              full,
    output logic              underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [15:0]       div_q, div_cnt_q, div_cnt_d;
    logic              enable_q;
    logic              unf_q, unf_d, ovf_q, ovf_d;
    logic [DATA_W-1:0] sample_q;
    logic              strobe_q, full_q;

    logic [1:0]        off;
    logic              wr_en, wr_data, wr_div, wr_ctrl;
    logic              tick, empty, pop, push_ok, push_rej;
    logic [31:0]       status;
    logic              unused_bits;

    assign sel      = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign off      = mem_addr[3:2];
    assign wr_en    = mem_we & sel;
    assign wr_data  = wr_en && (off == 2'd0);
    assign wr_div   = wr_en && (off == 2'd1);
    assign wr_ctrl  = wr_en && (off == 2'd3);

    assign tick     = enable_q && (div_cnt_q == div_q);
    assign empty    = (count_q == '0);
    assign pop      = tick && !empty;
    // A full FIFO still takes a store if the same cycle frees a slot.
    assign push_ok  = wr_data && ((count_q < CW'(DEPTH)) || pop);
    assign push_rej = wr_data && !push_ok;

    assign status   = {16'h0, 8'(count_q), 4'h0, ovf_q, unf_q, full_q, empty};
    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16]};

    assign sample_out    = sample_q;
    assign sample_strobe = strobe_q;
    assign full          = full_q;
    assign underflow     = unf_q;

    // Zero-latency register read mux for the core's load path.
    always_comb begin
        mem_rdata = '0;
        if (sel) begin
            case (off)
                2'd1:    mem_rdata = {16'h0, div_q};
                2'd2:    mem_rdata = status;
                2'd3:    mem_rdata = {31'h0, enable_q};
                default: mem_rdata = '0;
            endcase
        end
    end

    // Occupancy and divider next state; simultaneous push+pop keeps count.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        div_cnt_d = div_cnt_q + 16'd1;
        if (wr_div || !enable_q || tick)
            div_cnt_d = '0;
    end

    // Sticky flags: a set event in the same cycle beats a CTRL clear.
    always_comb begin
        unf_d = unf_q;
        ovf_d = ovf_q;
        if (wr_ctrl && mem_wdata[1]) unf_d = 1'b0;
        if (wr_ctrl && mem_wdata[2]) ovf_d = 1'b0;
        if (tick && empty)           unf_d = 1'b1;
        if (push_rej)                ovf_d = 1'b1;
    end

    // Control, pointer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            div_q     <= '0;
            div_cnt_q <= '0;
            enable_q  <= 1'b0;
            unf_q     <= 1'b0;
            ovf_q     <= 1'b0;
            sample_q  <= '0;
            strobe_q  <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            full_q    <= (count_d == CW'(DEPTH));
            div_cnt_q <= div_cnt_d;
            unf_q     <= unf_d;
            ovf_q     <= ovf_d;
            strobe_q  <= pop;
            if (pop) begin
                sample_q <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (wr_div)
                div_q <= mem_wdata[15:0];
            if (wr_ctrl)
                enable_q <= mem_wdata[0];
        end
    end

    // Sample storage; contents are discarded on reset via the pointers.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= mem_wdata[DATA_W-1:0];
    end
endmodule

// File: tb/tb_sample_out_port.sv
// Randomized + directed bench for sample_out_port against a queue-based model.
module tb_sample_out_port;
    localparam int          DATA_W = 8;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_DIV  = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_CTRL = BASE + 32'hC;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_we = 1'b0;
    logic [31:0]       mem_addr = '0;
    logic [31:0]       mem_wdata = '0;
    logic [31:0]       mem_rdata;
    logic              sel;
    logic [DATA_W-1:0] sample_out;
    logic              sample_strobe;
    logic              full;
    logic              underflow;

    sample_out_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .sel(sel),
        .sample_out(sample_out), .sample_strobe(sample_strobe),
        .full(full), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;

    // Reference model state
    logic [7:0]  q[$];
    int          m_div = 0;
    int          m_cnt = 0;
    bit          m_en = 0, m_unf = 0, m_ovf = 0, m_strb = 0;
    logic [7:0]  m_so = '0;
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive, check combinational read path, advance model, check outputs.
    task automatic step(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
        bit         m_sel, wr, tick, pop;
        int         sz;
        logic [1:0] off;
        logic [31:0] exp_rd;
        rst = r; mem_we = we; mem_addr = a; mem_wdata = d;
        #2;
        m_sel  = (a[31:4] == BASE[31:4]);
        off    = a[3:2];
        sz     = q.size();
        exp_rd = 32'h0;
        if (m_sel) begin
            if (off == 2'd1) exp_rd = m_div;
            if (off == 2'd2) exp_rd = {16'h0, 8'(sz), 4'h0, m_ovf, m_unf, sz == DEPTH, sz == 0};
            if (off == 2'd3) exp_rd = {31'h0, m_en};
        end
        chk("sel", {31'h0, sel}, {31'h0, m_sel});
        chk("rdata", mem_rdata, exp_rd);
        last_rd = mem_rdata;

        wr   = we && m_sel;
        tick = m_en && (m_cnt == m_div);
        pop  = tick && (sz > 0);
        if (r) begin
            q.delete();
            m_div = 0; m_cnt = 0; m_en = 0; m_unf = 0; m_ovf = 0; m_strb = 0; m_so = '0;
        end else begin
            m_strb = pop;
            if (pop) m_so = q.pop_front();
            if (wr && off == 2'd0) begin
                if (sz < DEPTH || pop) q.push_back(d[7:0]);
                else m_ovf = 1;
            end
            if (wr && off == 2'd3 && d[1]) m_unf = 0;
            if (wr && off == 2'd3 && d[2] && !(wr && off == 2'd0 && sz >= DEPTH && !pop)) m_ovf = 0;
            if (tick && sz == 0) m_unf = 1;
            if (wr && off == 2'd1 || !m_en || tick) m_cnt = 0;
            else m_cnt = m_cnt + 1;
            if (wr && off == 2'd1) m_div = int'(d[15:0]);
            if (wr && off == 2'd3) m_en = d[0];
        end

        @(posedge clk); #1;
        chk("sample_out", {24'h0, sample_out}, {24'h0, m_so});
        chk("strobe", {31'h0, sample_strobe}, {31'h0, m_strb});
        chk("full", {31'h0, full}, {31'h0, q.size() == DEPTH});
        chk("underflow", {31'h0, underflow}, {31'h0, m_unf});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, A_STAT, 32'h0);
    endtask

    initial begin
        @(posedge clk); #1;
        step(1, 0, A_STAT, 0);
        step(1, 0, A_STAT, 0);

        // Reset state
        step(0, 0, A_STAT, 0);
        chk("rst_status", last_rd, 32'h0000_0001);

        // Three samples at DIV=3, then underflow
        step(0, 1, A_DIV, 32'd3);
        step(0, 1, A_DATA, 32'h11);
        step(0, 1, A_DATA, 32'h22);
        step(0, 1, A_DATA, 32'h33);
        step(0, 1, A_CTRL, 32'h1);
        idle(20);
        chk("hold_last", {24'h0, sample_out}, 32'h33);
        chk("unf_set", {31'h0, underflow}, 32'h1);

        // Overflow with enable off
        step(0, 1, A_CTRL, 32'h0);
        step(0, 1, A_CTRL, 32'h6);
        for (int i = 0; i < 17; i++) step(0, 1, A_DATA, 32'h40 + i);
        step(0, 0, A_STAT, 0);
        chk("ovf_status", last_rd, 32'h0000_100A);
        step(0, 1, A_CTRL, 32'h4);
        step(0, 0, A_STAT, 0);
        chk("ovf_clear", last_rd, 32'h0000_1002);

        // Full FIFO, DIV=0, store every cycle across pointer wrap
        step(0, 1, A_DIV, 32'd0);
        step(0, 1, A_CTRL, 32'h1);
        for (int i = 0; i < 40; i++) step(0, 1, A_DATA, 32'h80 + i);
        step(0, 0, A_STAT, 0);
        chk("stream_status", last_rd, 32'h0000_1002);
        idle(20);

        // DIV rewrite mid-count
        step(0, 1, A_CTRL, 32'h0);
        step(0, 1, A_DIV, 32'hFFFF);
        step(0, 1, A_DATA, 32'hA1);
        step(0, 1, A_DATA, 32'hA2);
        step(0, 1, A_DATA, 32'hA3);
        step(0, 1, A_CTRL, 32'h3);
        idle(5);
        step(0, 1, A_DIV, 32'd1);
        idle(1);
        chk("div_rw_early", {31'h0, sample_strobe}, 32'h0);
        idle(1);
        chk("div_rw_strobe", {31'h0, sample_strobe}, 32'h1);
        idle(8);

        // Reset mid-stream with 5 queued samples
        step(0, 1, A_CTRL, 32'h0);
        step(0, 1, A_DIV, 32'd7);
        for (int i = 0; i < 5; i++) step(0, 1, A_DATA, 32'hC0 + i);
        step(1, 0, A_STAT, 0);
        step(0, 0, A_STAT, 0);
        chk("rst_mid_status", last_rd, 32'h0000_0001);
        chk("rst_mid_sample", {24'h0, sample_out}, 32'h0);
        step(0, 0, A_DIV, 0);
        chk("rst_mid_div", last_rd, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int          op;
            logic [31:0] a;
            op = $urandom_range(0, 99);
            if (op < 40)      step(0, 1, A_DATA | $urandom_range(0, 3), $urandom());
            else if (op < 48) step(0, 1, A_DIV, $urandom_range(0, 4) | ($urandom() & 32'hFFFF_0000));
            else if (op < 56) step(0, 1, A_CTRL, {$urandom_range(0, 3), ($urandom_range(0, 3) != 0)});
            else if (op < 58) step(1, $urandom_range(0, 1), A_DATA, $urandom());
            else if (op < 68) begin
                a = BASE ^ (32'h1 << $urandom_range(4, 31));
                step(0, $urandom_range(0, 1), a | ($urandom() & 32'hF), $urandom());
            end else          step(0, 0, BASE | ($urandom() & 32'hF), $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/sample_out_port.md
# sample_out_port

Memory-mapped waveform output stage sitting directly downstream of the single-cycle RISC-V core's data-memory port. Store instructions from the core push sample words into a FIFO; a programmable divider drains that FIFO at a fixed sample rate onto a registered sample bus with a one-cycle strobe, which drives the external DAC of the function generator. Status and control are readable and writable over the same data-memory bus.

## Interface
- DATA_W, 8, sample width; taken from mem_wdata[DATA_W-1:0].
- DEPTH, 16, FIFO depth in samples; power of two, at least 2.
- BASE_ADDR, 32'h0000_1000, word-aligned base of the 16-byte register window.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_we  in  1  core store enable. Same-cycle as the address and data.
- mem_addr  in  32  core data address.
- mem_wdata  in  32  core store data.
- mem_rdata  out  32  combinational read data for the addressed register. 0 when not selected.
- sel  out  1  combinational. 1 when mem_addr[31:4] == BASE_ADDR[31:4]. The top-level muxes mem_rdata into the load path and gates data-memory writes.
- sample_out  out  DATA_W  registered current sample.
- sample_strobe  out  1  registered. High for exactly one cycle when sample_out takes a new value.
- full  out  1  registered FIFO-full flag.
- underflow  out  1  sticky underflow flag. Mirrors STATUS bit.

## Operation
- Register offsets are decoded from mem_addr[3:2]. Writes take effect only when mem_we=1 and sel=1.
  - 0x0 DATA (W): push mem_wdata[DATA_W-1:0]. Reads return 0.
  - 0x4 DIV (R/W, 16 bits): sample period is DIV+1 cycles. A write also clears the divider counter.
  - 0x8 STATUS (R): bit0 empty, bit1 full, bit2 underflow, bit3 overflow, bits[15:8] count.
  - 0xC CTRL (R/W): bit0 enable. Writing 1 to bit1 clears underflow. Writing 1 to bit2 clears overflow. Bits 1 and 2 read 0.
- Divider: a 16-bit counter runs only while enable=1.
  - When counter == DIV, a tick fires and the counter returns to 0; otherwise it increments.
  - While enable=0, the counter is held at 0.
  - DIV=0 gives a tick every cycle.
- On a tick with count>0: pop the head into sample_out and assert sample_strobe for the next cycle.
- On a tick with count==0: sample_out holds its value, no strobe, underflow sets.
- Push is accepted when count<DEPTH, or when a pop occurs in the same cycle.
  - A rejected push drops the data and sets overflow.
  - On a simultaneous push and pop, count is unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Underflow and overflow are sticky until cleared through CTRL or by reset.
  - If a clear and a new set event occur in the same cycle, set wins.
- Disabling the block leaves FIFO contents and sample_out intact.

## Timing
- Reset values:
  - sample_out=0, sample_strobe=0, full=0, underflow=0, overflow=0.
  - count=0, pointers=0, DIV=0, enable=0, divider counter=0.
- Reset asserted mid-stream discards FIFO contents on that edge. The next cycle shows empty=1.
- Store at edge N: count and full update at edge N, and are visible in STATUS in cycle N+1.
- Earliest pop of that sample is edge N+1, when enable=1, DIV=0 and the FIFO was empty.
- A tick decided in cycle T updates sample_out at edge T. sample_strobe is high in cycle T+1 only.
- With enable=1 and DIV=D, consecutive strobes are exactly D+1 cycles apart while data is available.
- Setting enable, or writing DIV, at edge E makes the first tick occur in cycle E+D.
- mem_rdata and sel have zero latency, so the core's single-cycle load completes in the same cycle.

## Test plan
- After reset: read STATUS -> 0x0000_0001. sample_out=0, strobe never asserted.
- Set DIV=3, push 0x11, 0x22, 0x33, then set enable=1:
  - sample_out goes 0x11, 0x22, 0x33 with strobes exactly 4 cycles apart.
  - One tick later underflow=1, sample_out holds 0x33.
- With enable=0, push 17 samples into DEPTH=16:
  - full=1, STATUS overflow=1, count=16.
  - The 17th value is never output.
  - Writing CTRL=0x4 clears overflow.
- Full FIFO, enable=1, DIV=0, store on every cycle:
  - Every push is accepted, count stays at 16, no overflow.
  - Output order is preserved across pointer wrap.
- Set DIV=0xFFFF, then rewrite DIV=1 mid-count -> next strobe arrives 2 cycles after the write.
- Assert rst while the FIFO holds 5 samples -> STATUS=0x0000_0001, sample_out=0, DIV=0 on the following cycle.
